// File: rtl/uart_pkg.sv
// Shared types and constants for the UART MMIO responder.
// Holds the TX/RX FSM state enums, the register offsets inside the UART
// window, and the bit positions of the STATUS register.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // STATUS = {4'b0, frame_err, rx_overrun, tx_full, rx_data_present}
  localparam int STAT_RX_PRESENT = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_RX_OVERRUN = 2;
  localparam int STAT_FRAME_ERR  = 3;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   push, din       write request and data (ignored while full unless a pop
//                   happens in the same cycle)
//   pop             read request (ignored while empty)
//   head            entry at the read pointer, valid while !empty
//   full, empty     occupancy flags, derived from registered pointers only
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push on a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// Memory-mapped 8N1 UART with TX and RX FIFOs.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   tx_wen, rx_ren    bus write / read strobes, already decoded to this window
//   uart_addr         byte offset: 0 = DATA, 4 = STATUS, others read as 0
//   uart_din          write data (DATA writes push into the TX FIFO)
//   uart_dout         read data, combinational so it is valid with the strobe
//   rx                asynchronous serial input
//   tx                serial output, LSB first
//   tx_full           TX FIFO full
//   rx_data_present   RX FIFO not empty
//
// TX FSM:  IDLE  | line high, waiting for a queued byte
//          START | start bit (0) for BAUD_DIV cycles
//          DATA  | 8 data bits, LSB first
//          STOP  | stop bit (1); chains straight into START if more queued
// RX FSM:  IDLE  | waiting for a low level on the synchronized line
//          START | confirm start at mid-bit (8 ticks), else treat as glitch
//          DATA  | sample 8 bits every 16 ticks
//          STOP  | sample stop bit; 1 pushes the byte, 0 flags frame_err
module uart_mmio_responder
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wen,
  input  logic       rx_ren,
  input  logic [2:0] uart_addr,
  input  logic [7:0] uart_din,
  output logic [7:0] uart_dout,
  input  logic       rx,
  output logic       tx,
  output logic       tx_full,
  output logic       rx_data_present
);

  localparam int CW       = $clog2(BAUD_DIV);
  localparam int TICK_DIV = BAUD_DIV / 16;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  // ---------------- bus decode ----------------
  logic       tx_empty, rx_empty, rx_full;
  logic [7:0] tx_head, rx_head;
  logic       tx_pop, rx_push, rx_pop;
  logic       frame_err, rx_overrun, set_fe, set_ov, status_clr;

  assign rx_pop     = rx_ren && (uart_addr == ADDR_DATA) && !rx_empty;
  assign status_clr = rx_ren && (uart_addr == ADDR_STATUS);
  assign set_ov     = rx_push && rx_full && !rx_pop;
  assign rx_data_present = !rx_empty;

  always_comb begin
    uart_dout = 8'h00;
    case (uart_addr)
      ADDR_DATA:   if (!rx_empty) uart_dout = rx_head;
      ADDR_STATUS: uart_dout = {4'b0, frame_err, rx_overrun, tx_full, rx_data_present};
      default:     uart_dout = 8'h00;
    endcase
  end

  // A set in the same cycle as a STATUS-read clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (set_fe)          frame_err  <= 1'b1;
      else if (status_clr) frame_err  <= 1'b0;
      if (set_ov)          rx_overrun <= 1'b1;
      else if (status_clr) rx_overrun <= 1'b0;
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wen && (uart_addr == ADDR_DATA)),
    .din   (uart_din),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // ---------------- transmitter ----------------
  tx_state_t      tx_state, tx_state_nx;
  logic [CW-1:0]  tx_cnt, tx_cnt_nx;
  logic [7:0]     tx_shift, tx_shift_nx;
  logic [2:0]     tx_bit, tx_bit_nx;
  logic           tx_line, tx_line_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_shift <= tx_shift_nx;
      tx_bit   <= tx_bit_nx;
      tx_line  <= tx_line_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_shift_nx = tx_shift;
    tx_bit_nx   = tx_bit;
    tx_pop      = 1'b0;
    tx_line_nx  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shift_nx = tx_head;
          tx_cnt_nx   = BAUD_LAST;
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx   = BAUD_LAST;
          tx_bit_nx   = 3'd0;
          tx_state_nx = TX_DATA;
        end else tx_cnt_nx = tx_cnt - 1'b1;
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_nx   = BAUD_LAST;
          tx_shift_nx = {1'b0, tx_shift[7:1]};
          tx_bit_nx   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
        end else tx_cnt_nx = tx_cnt - 1'b1;
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          // Chain the next byte directly so back-to-back frames have no gap.
          if (!tx_empty) begin
            tx_pop      = 1'b1;
            tx_shift_nx = tx_head;
            tx_cnt_nx   = BAUD_LAST;
            tx_state_nx = TX_START;
          end else tx_state_nx = TX_IDLE;
        end else tx_cnt_nx = tx_cnt - 1'b1;
      end
      default: tx_state_nx = TX_IDLE;
    endcase
    // Line level is registered from the next state so tx never glitches.
    case (tx_state_nx)
      TX_START: tx_line_nx = 1'b0;
      TX_DATA:  tx_line_nx = tx_shift_nx[0];
      default:  tx_line_nx = 1'b1;
    endcase
  end

  assign tx = tx_line;

  // ---------------- receiver ----------------
  logic           rx_s1, rx_s2;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  rx_state_t      rx_state, rx_state_nx;
  logic [3:0]     rx_samp, rx_samp_nx;
  logic [2:0]     rx_bit, rx_bit_nx;
  logic [7:0]     rx_shift, rx_shift_nx;

  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      tick_cnt <= '0;
      rx_state <= RX_IDLE;
      rx_samp  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      tick_cnt <= tick ? TICK_LAST : tick_cnt - 1'b1;
      rx_state <= rx_state_nx;
      rx_samp  <= rx_samp_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_samp_nx  = rx_samp;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_push     = 1'b0;
    set_fe      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_samp_nx  = 4'd7;
          rx_state_nx = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_samp == 4'd0) begin
            rx_samp_nx  = 4'd15;
            rx_bit_nx   = 3'd0;
            rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
          end else rx_samp_nx = rx_samp - 4'd1;
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_samp == 4'd0) begin
            rx_shift_nx = {rx_s2, rx_shift[7:1]};
            rx_samp_nx  = 4'd15;
            rx_bit_nx   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
          end else rx_samp_nx = rx_samp - 4'd1;
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_samp == 4'd0) begin
            rx_push     = rx_s2;
            set_fe      = !rx_s2;
            rx_state_nx = RX_IDLE;
          end else rx_samp_nx = rx_samp - 4'd1;
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule
